// File: rtl/dmem_arbiter.sv
// Arbiter sharing the single-port 256x64 data memory between the CPU memory stage
// and the debug/loader port. CPU has priority; a starvation counter guarantees dbg progress.
module dmem_arbiter #(
    parameter logic [63:0] MAX_ADDR     = 64'd2047,
    parameter int          STARVE_LIMIT = 4
) (
    input  logic        clk_i,
    input  logic        rst_n_i,

    input  logic        cpu_req_i,
    input  logic        cpu_we_i,
    input  logic [63:0] cpu_addr_i,
    input  logic [63:0] cpu_wdata_i,
    output logic        cpu_done_o,
    output logic [63:0] cpu_rdata_o,
    output logic        cpu_err_o,
    output logic        cpu_stall_o,

    input  logic        dbg_req_i,
    input  logic        dbg_we_i,
    input  logic [63:0] dbg_addr_i,
    input  logic [63:0] dbg_wdata_i,
    output logic        dbg_done_o,
    output logic [63:0] dbg_rdata_o,
    output logic        dbg_err_o,

    output logic        mem_en_o,
    output logic        mem_we_o,
    output logic [7:0]  mem_addr_o,
    output logic [63:0] mem_wdata_o,
    input  logic [63:0] mem_rdata_i
);

    localparam int             CW    = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0]  LIMIT = CW'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t         state_q,     state_d;
    logic [CW-1:0]  starve_q,    starve_d;
    logic           owner_q,     owner_d;
    logic           rd_q,        rd_d;
    logic           mem_en_q,    mem_en_d;
    logic           mem_we_q,    mem_we_d;
    logic [7:0]     mem_addr_q,  mem_addr_d;
    logic [63:0]    mem_wdata_q, mem_wdata_d;
    logic           cpu_done_q,  cpu_done_d;
    logic           dbg_done_q,  dbg_done_d;
    logic           cpu_err_q,   cpu_err_d;
    logic           dbg_err_q,   dbg_err_d;

    logic           grant_dbg;
    logic           sel_we;
    logic [63:0]    sel_addr;
    logic [63:0]    sel_wdata;
    logic           addr_bad;

    // owner_q: 0 = CPU, 1 = dbg; dbg only wins a contested slot once the CPU has starved it
    assign grant_dbg = dbg_req_i & (~cpu_req_i | (starve_q == LIMIT));
    assign sel_we    = grant_dbg ? dbg_we_i    : cpu_we_i;
    assign sel_addr  = grant_dbg ? dbg_addr_i  : cpu_addr_i;
    assign sel_wdata = grant_dbg ? dbg_wdata_i : cpu_wdata_i;
    assign addr_bad  = (sel_addr > MAX_ADDR);

    always_comb begin
        state_d     = state_q;
        starve_d    = starve_q;
        owner_d     = owner_q;
        rd_d        = rd_q;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = '0;
        mem_wdata_d = '0;
        cpu_done_d  = 1'b0;
        dbg_done_d  = 1'b0;
        cpu_err_d   = 1'b0;
        dbg_err_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (cpu_req_i | dbg_req_i) begin
                    owner_d = grant_dbg;
                    rd_d    = ~sel_we & ~addr_bad;
                    if (grant_dbg) begin
                        starve_d = '0;
                    end else if (dbg_req_i && (starve_q < LIMIT)) begin
                        starve_d = starve_q + CW'(1);
                    end
                    // Out-of-range accesses skip the RAM and answer one cycle early
                    if (addr_bad) begin
                        state_d    = RESP;
                        cpu_done_d = ~grant_dbg;
                        dbg_done_d = grant_dbg;
                        cpu_err_d  = ~grant_dbg;
                        dbg_err_d  = grant_dbg;
                    end else begin
                        state_d     = ISSUE;
                        mem_en_d    = 1'b1;
                        mem_we_d    = sel_we;
                        mem_addr_d  = sel_addr[10:3];
                        mem_wdata_d = sel_wdata;
                    end
                end
            end
            ISSUE: begin
                state_d    = RESP;
                cpu_done_d = ~owner_q;
                dbg_done_d = owner_q;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= IDLE;
            starve_q    <= '0;
            owner_q     <= 1'b0;
            rd_q        <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cpu_done_q  <= 1'b0;
            dbg_done_q  <= 1'b0;
            cpu_err_q   <= 1'b0;
            dbg_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            starve_q    <= starve_d;
            owner_q     <= owner_d;
            rd_q        <= rd_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cpu_done_q  <= cpu_done_d;
            dbg_done_q  <= dbg_done_d;
            cpu_err_q   <= cpu_err_d;
            dbg_err_q   <= dbg_err_d;
        end
    end

    // The synchronous RAM answers in RESP, so read data is steered straight through
    assign cpu_rdata_o = (cpu_done_q && rd_q) ? mem_rdata_i : '0;
    assign dbg_rdata_o = (dbg_done_q && rd_q) ? mem_rdata_i : '0;

    assign cpu_done_o  = cpu_done_q;
    assign cpu_err_o   = cpu_err_q;
    assign dbg_done_o  = dbg_done_q;
    assign dbg_err_o   = dbg_err_q;
    assign cpu_stall_o = cpu_req_i & ~cpu_done_q;

    assign mem_en_o    = mem_en_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios followed by random traffic,
// every cycle compared against a transaction-level reference model.
module tb_dmem_arbiter;

    localparam logic [63:0] MAX_ADDR     = 64'd2047;
    localparam int          STARVE_LIMIT = 4;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        cpu_req_i, cpu_we_i;
    logic [63:0] cpu_addr_i, cpu_wdata_i;
    logic        cpu_done_o, cpu_err_o, cpu_stall_o;
    logic [63:0] cpu_rdata_o;
    logic        dbg_req_i, dbg_we_i;
    logic [63:0] dbg_addr_i, dbg_wdata_i;
    logic        dbg_done_o, dbg_err_o;
    logic [63:0] dbg_rdata_o;
    logic        mem_en_o, mem_we_o;
    logic [7:0]  mem_addr_o;
    logic [63:0] mem_wdata_o;
    logic [63:0] mem_rdata_i = '0;

    logic [63:0] ram    [256] = '{default: 64'd0};
    logic [63:0] refMem [256] = '{default: 64'd0};

    int checks = 0;
    int errors = 0;

    // Reference model: remaining cycles of the current access plus the access itself
    int          left = 0;
    int          starve = 0;
    logic        tDbg, tWe, tErr;
    logic [7:0]  tIdx;
    logic [63:0] tData;
    logic        eCpuDone, eDbgDone, eCpuErr, eDbgErr, eMemEn, eMemWe;
    logic [63:0] eCpuRdata, eDbgRdata, eMemWdata;
    logic [7:0]  eMemAddr;

    logic autoMode = 1'b0;
    logic cpuActive = 1'b0;
    logic dbgActive = 1'b0;
    int   doneIdx;

    dmem_arbiter #(.MAX_ADDR(MAX_ADDR), .STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i),
        .cpu_req_i(cpu_req_i), .cpu_we_i(cpu_we_i), .cpu_addr_i(cpu_addr_i),
        .cpu_wdata_i(cpu_wdata_i), .cpu_done_o(cpu_done_o), .cpu_rdata_o(cpu_rdata_o),
        .cpu_err_o(cpu_err_o), .cpu_stall_o(cpu_stall_o),
        .dbg_req_i(dbg_req_i), .dbg_we_i(dbg_we_i), .dbg_addr_i(dbg_addr_i),
        .dbg_wdata_i(dbg_wdata_i), .dbg_done_o(dbg_done_o), .dbg_rdata_o(dbg_rdata_o),
        .dbg_err_o(dbg_err_o),
        .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
    );

    // Free-running clock, 10 time units per cycle
    always #5 clk_i = ~clk_i;

    // Behavioural synchronous RAM: read data appears the cycle after the enable
    always @(posedge clk_i) begin
        if (mem_en_o) begin
            if (mem_we_o) ram[mem_addr_o] <= mem_wdata_o;
            else          mem_rdata_i     <= ram[mem_addr_o];
        end
    end

    // Safety net in case something goes badly wrong with the clocking
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clearExpect();
        eCpuDone = 0; eDbgDone = 0; eCpuErr = 0; eDbgErr = 0;
        eCpuRdata = '0; eDbgRdata = '0;
        eMemEn = 0; eMemWe = 0; eMemAddr = '0; eMemWdata = '0;
    endtask

    task automatic modelReset();
        left = 0;
        starve = 0;
        clearExpect();
    endtask

    // Consumes the inputs of the current cycle and predicts the outputs of the next one
    task automatic modelAdvance();
        logic [63:0] a;
        logic [63:0] rd;
        clearExpect();
        if (left == 0) begin
            if (cpu_req_i || dbg_req_i) begin
                tDbg = dbg_req_i && (!cpu_req_i || starve == STARVE_LIMIT);
                if (tDbg) starve = 0;
                else if (dbg_req_i && starve < STARVE_LIMIT) starve = starve + 1;
                a     = tDbg ? dbg_addr_i : cpu_addr_i;
                tWe   = tDbg ? dbg_we_i : cpu_we_i;
                tData = tDbg ? dbg_wdata_i : cpu_wdata_i;
                tIdx  = 8'((a / 8) % 256);
                tErr  = (a > MAX_ADDR);
                left  = tErr ? 1 : 2;
            end
        end else begin
            left = left - 1;
        end
        if (left == 2) begin
            eMemEn = 1; eMemWe = tWe; eMemAddr = tIdx; eMemWdata = tData;
        end else if (left == 1) begin
            rd = (tErr || tWe) ? 64'd0 : refMem[tIdx];
            if (!tErr && tWe) refMem[tIdx] = tData;
            if (tDbg) begin eDbgDone = 1; eDbgErr = tErr; eDbgRdata = rd; end
            else      begin eCpuDone = 1; eCpuErr = tErr; eCpuRdata = rd; end
        end
    endtask

    function automatic logic [63:0] randAddr();
        logic [63:0] a;
        case ($urandom_range(0, 9))
            0:       a = 64'd2048 + 64'($urandom_range(0, 7));
            1:       a = 64'd2047;
            2:       a = 64'hFFFF_FFFF_FFFF_FFF8;
            default: a = 64'($urandom_range(0, 127));
        endcase
        return a;
    endfunction

    // Random requesters: each holds its request until it sees its own done pulse
    task automatic applyStimulus();
        if (cpuActive && cpu_done_o) cpuActive = 0;
        if (!cpuActive && $urandom_range(0, 2) != 0) begin
            cpuActive   = 1;
            cpu_we_i    = 1'($urandom_range(0, 1));
            cpu_addr_i  = randAddr();
            cpu_wdata_i = {$urandom, $urandom};
        end
        cpu_req_i = cpuActive;
        if (dbgActive && dbg_done_o) dbgActive = 0;
        if (!dbgActive && $urandom_range(0, 2) != 0) begin
            dbgActive   = 1;
            dbg_we_i    = 1'($urandom_range(0, 1));
            dbg_addr_i  = randAddr();
            dbg_wdata_i = {$urandom, $urandom};
        end
        dbg_req_i = dbgActive;
    endtask

    task automatic checkOutput();
        check("cpu_done",  64'(cpu_done_o),  64'(eCpuDone));
        check("dbg_done",  64'(dbg_done_o),  64'(eDbgDone));
        check("cpu_err",   64'(cpu_err_o),   64'(eCpuErr));
        check("dbg_err",   64'(dbg_err_o),   64'(eDbgErr));
        check("cpu_rdata", cpu_rdata_o,      eCpuRdata);
        check("dbg_rdata", dbg_rdata_o,      eDbgRdata);
        check("mem_en",    64'(mem_en_o),    64'(eMemEn));
        check("mem_we",    64'(mem_we_o),    64'(eMemWe));
        check("mem_addr",  64'(mem_addr_o),  64'(eMemAddr));
        check("mem_wdata", mem_wdata_o,      eMemWdata);
        check("cpu_stall", 64'(cpu_stall_o), 64'(cpu_req_i & ~eCpuDone));
    endtask

    // One clock cycle: inputs are settled at the falling edge, outputs checked at the next one
    task automatic step();
        if (autoMode) applyStimulus();
        modelAdvance();
        @(posedge clk_i);
        @(negedge clk_i);
        checkOutput();
    endtask

    // Directed scenarios first, then a long stretch of random traffic
    initial begin
        rst_n_i = 0;
        cpu_req_i = 0; cpu_we_i = 0; cpu_addr_i = '0; cpu_wdata_i = '0;
        dbg_req_i = 0; dbg_we_i = 0; dbg_addr_i = '0; dbg_wdata_i = '0;
        modelReset();
        repeat (2) @(negedge clk_i);
        checkOutput();
        rst_n_i = 1;

        $display("[TB] CPU write then read of 0x40");
        cpu_req_i = 1; cpu_we_i = 1; cpu_addr_i = 64'h40; cpu_wdata_i = 64'hDEAD_BEEF;
        step();
        check("t1_issue_addr", 64'(mem_addr_o), 64'd8);
        step();
        cpu_req_i = 0;
        step();
        cpu_req_i = 1; cpu_we_i = 0; cpu_wdata_i = '0;
        step();
        step();
        check("t1_read_rdata", cpu_rdata_o, 64'hDEAD_BEEF);
        check("t1_read_done", 64'(cpu_done_o), 64'd1);
        cpu_req_i = 0;
        step();

        $display("[TB] dbg read of out-of-range address 2048");
        dbg_req_i = 1; dbg_we_i = 0; dbg_addr_i = 64'd2048;
        step();
        check("t2_err", 64'(dbg_err_o), 64'd1);
        check("t2_mem_en", 64'(mem_en_o), 64'd0);
        dbg_req_i = 0;
        step();

        $display("[TB] simultaneous first requests");
        cpu_req_i = 1; cpu_we_i = 0; cpu_addr_i = 64'h40;
        dbg_req_i = 1; dbg_we_i = 1; dbg_addr_i = 64'h80; dbg_wdata_i = 64'h0123_4567_89AB_CDEF;
        step();
        step();
        check("t4_cpu_first", 64'(cpu_done_o), 64'd1);
        check("t4_stall_drop", 64'(cpu_stall_o), 64'd0);
        cpu_req_i = 0;
        step();
        step();
        step();
        check("t4_dbg_next", 64'(dbg_done_o), 64'd1);
        dbg_req_i = 0;
        step();

        $display("[TB] both requesting continuously");
        cpu_req_i = 1; cpu_we_i = 0; cpu_addr_i = 64'h80;
        dbg_req_i = 1; dbg_we_i = 1; dbg_addr_i = 64'h88; dbg_wdata_i = 64'h5555_AAAA_5555_AAAA;
        doneIdx = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (cpu_done_o || dbg_done_o) begin
                check("t3_owner", 64'(dbg_done_o), 64'((doneIdx % 5) == 4));
                doneIdx++;
            end
        end
        check("t3_count", 64'(doneIdx), 64'd10);
        cpu_req_i = 0; dbg_req_i = 0;
        step();

        $display("[TB] CPU drops request during ISSUE");
        cpu_req_i = 1; cpu_we_i = 0; cpu_addr_i = 64'h40;
        step();
        cpu_req_i = 0;
        step();
        check("t6_done", 64'(cpu_done_o), 64'd1);
        repeat (3) step();

        $display("[TB] reset during ISSUE of a write");
        cpu_req_i = 1; cpu_we_i = 1; cpu_addr_i = 64'h100; cpu_wdata_i = 64'hCAFE_F00D;
        step();
        rst_n_i = 0;
        cpu_req_i = 0;
        #1;
        modelReset();
        check("t5_mem_en_rst", 64'(mem_en_o), 64'd0);
        checkOutput();
        @(posedge clk_i);
        @(negedge clk_i);
        checkOutput();
        rst_n_i = 1;
        cpu_req_i = 1; cpu_we_i = 0; cpu_addr_i = 64'h100;
        step();
        step();
        check("t5_read_done", 64'(cpu_done_o), 64'd1);
        check("t5_read_rdata", cpu_rdata_o, 64'd0);
        cpu_req_i = 0;
        step();

        $display("[TB] random traffic");
        autoMode = 1;
        repeat (600) step();
        autoMode = 0;
        cpu_req_i = 0; dbg_req_i = 0;
        repeat (4) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
